// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: condition codes and FSM states.
// The optional taken-branch counter is enabled with BRANCH_STATS_EN.
package branch_pkg;

  typedef enum logic [2:0] {
    COND_ALWAYS  = 3'b000,
    COND_ZERO    = 3'b001,
    COND_EQ      = 3'b010,
    COND_GT      = 3'b011,
    COND_NE      = 3'b100,
    COND_LE      = 3'b101,
    COND_NONZERO = 3'b110,
    COND_NEVER   = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_FLAGS = 2'd1,
    HALTED     = 2'd2
  } state_e;

  localparam logic [7:0] TAKEN_CNT_MAX = 8'hFF;

endpackage

// File: rtl/branch_resolver_if.sv
// Request/response bundle between the instruction front end and the branch resolver.
// TakenCount exists only when BRANCH_STATS_EN is defined.
interface branch_resolver_if #(
  parameter int W = 8
);
  logic [2:0]   Flags;
  logic         CmpEn;
  logic         Advance;
  logic         BrReq;
  logic [2:0]   BrCond;
  logic [W-1:0] BrTarget;
  logic [W-1:0] PC;
  logic         Stall;
  logic         BrDone;
  logic         Taken;
  logic         Done;
`ifdef BRANCH_STATS_EN
  logic [7:0]   TakenCount;
`endif

  modport master (
    output Flags, CmpEn, Advance, BrReq, BrCond, BrTarget,
    input  PC, Stall, BrDone, Taken, Done
`ifdef BRANCH_STATS_EN
    , input TakenCount
`endif
  );

  modport slave (
    input  Flags, CmpEn, Advance, BrReq, BrCond, BrTarget,
    output PC, Stall, BrDone, Taken, Done
`ifdef BRANCH_STATS_EN
    , output TakenCount
`endif
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition evaluator: maps comparator flags and a condition code to taken.
// Flags: [2]=A is zero, [1]=A==B, [0]=A>B unsigned.
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] Flags,
  input  cond_e      cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS:  taken = 1'b1;
      COND_ZERO:    taken = Flags[2];
      COND_EQ:      taken = Flags[1];
      COND_GT:      taken = Flags[0];
      COND_NE:      taken = ~Flags[1];
      COND_LE:      taken = ~Flags[0];
      COND_NONZERO: taken = ~Flags[2];
      COND_NEVER:   taken = 1'b0;
      default:      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Program-counter sequencer that resolves conditional branches, stalling one cycle when the
// comparator result is not ready yet. BRANCH_STATS_EN adds a saturating taken-branch counter.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int           W         = 8,
  parameter logic [W-1:0] HALT_ADDR = {W{1'b1}}
) (
  input logic              Clk,
  input logic              reset,
  branch_resolver_if.slave bus
);

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] target_q, target_d;
  cond_e        cond_q, cond_d;
  logic         br_done_q, br_done_d;
  logic         taken_q, taken_d;
  logic         done_q, done_d;

  logic         stall;
  logic         resolve;
  logic         pc_update;
  logic [W-1:0] res_target;
  logic [W-1:0] pc_inc;
  cond_e        eval_cond;
  logic         branch_taken;

  assign pc_inc    = pc_q + W'(1);
  // A parked branch is judged with its latched condition against the now-valid flags.
  assign eval_cond = (state_q == WAIT_FLAGS) ? cond_q : cond_e'(bus.BrCond);

  cond_eval u_cond_eval (
    .Flags (bus.Flags),
    .cond  (eval_cond),
    .taken (branch_taken)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    cond_d     = cond_q;
    br_done_d  = 1'b0;
    taken_d    = taken_q;
    stall      = 1'b0;
    resolve    = 1'b0;
    pc_update  = 1'b0;
    res_target = bus.BrTarget;

    case (state_q)
      RUN: begin
        if (bus.BrReq && bus.CmpEn) begin
          stall    = 1'b1;
          cond_d   = cond_e'(bus.BrCond);
          target_d = bus.BrTarget;
          state_d  = WAIT_FLAGS;
        end else if (bus.BrReq) begin
          resolve = 1'b1;
        end else if (bus.Advance) begin
          pc_d      = pc_inc;
          pc_update = 1'b1;
        end
      end
      WAIT_FLAGS: begin
        stall      = 1'b1;
        resolve    = 1'b1;
        res_target = target_q;
        state_d    = RUN;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = RUN;
    endcase

    if (resolve) begin
      br_done_d = 1'b1;
      taken_d   = branch_taken;
      pc_d      = branch_taken ? res_target : pc_inc;
      pc_update = 1'b1;
    end

    // Landing on the halt address, by stepping or by branching, stops execution.
    if (pc_update && (pc_d == HALT_ADDR)) begin
      state_d = HALTED;
    end

    done_d = (state_d == HALTED);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      target_q  <= '0;
      cond_q    <= COND_ALWAYS;
      br_done_q <= 1'b0;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      cond_q    <= cond_d;
      br_done_q <= br_done_d;
      taken_q   <= taken_d;
      done_q    <= done_d;
    end
  end

  assign bus.PC     = pc_q;
  assign bus.Stall  = stall;
  assign bus.BrDone = br_done_q;
  assign bus.Taken  = taken_q;
  assign bus.Done   = done_q;

`ifdef BRANCH_STATS_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (resolve && branch_taken && (count_q != TAKEN_CNT_MAX)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.TakenCount = count_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model. BRANCH_STATS_EN adds counter checks.
module tb_branch_resolver;
  import branch_pkg::*;

  localparam int         W    = 8;
  localparam logic [7:0] HALT = 8'h10;

  logic Clk   = 1'b0;
  logic reset = 1'b0;

  branch_resolver_if #(.W(W)) bus ();

  branch_resolver #(.W(W), .HALT_ADDR(HALT)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Model state: what the resolver must look like, derived from the behavioural rules.
  int m_pc      = 0;
  bit m_waiting = 1'b0;
  bit m_halted  = 1'b0;
  int m_cond    = 0;
  int m_target  = 0;
  bit m_brdone  = 1'b0;
  bit m_taken   = 1'b0;
  int m_count   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_true(input int c, input logic [2:0] f);
    case (c)
      0: return 1'b1;
      1: return f[2];
      2: return f[1];
      3: return f[0];
      4: return !f[1];
      5: return !f[0];
      6: return !f[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_new_pc(input int v);
    m_pc = v % 256;
    if (m_pc == int'(HALT)) m_halted = 1'b1;
  endtask

  task automatic model_resolve(input int c, input int tgt, input logic [2:0] f);
    bit t;
    t         = cond_true(c, f);
    m_brdone  = 1'b1;
    m_taken   = t;
    if (t && m_count < 255) m_count = m_count + 1;
    model_new_pc(t ? tgt : m_pc + 1);
  endtask

  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      m_pc = 0; m_waiting = 0; m_halted = 0; m_cond = 0; m_target = 0;
      m_brdone = 0; m_taken = 0; m_count = 0;
    end else if (m_halted) begin
      m_brdone = 1'b0;
    end else if (m_waiting) begin
      m_waiting = 1'b0;
      model_resolve(m_cond, m_target, bus.Flags);
    end else if (bus.BrReq && bus.CmpEn) begin
      m_waiting = 1'b1;
      m_cond    = int'(bus.BrCond);
      m_target  = int'(bus.BrTarget);
      m_brdone  = 1'b0;
    end else if (bus.BrReq) begin
      model_resolve(int'(bus.BrCond), int'(bus.BrTarget), bus.Flags);
    end else if (bus.Advance) begin
      m_brdone = 1'b0;
      model_new_pc(m_pc + 1);
    end else begin
      m_brdone = 1'b0;
    end
  end

  always @(negedge Clk) begin
    checkOutput("model_pc",     32'(bus.PC),     32'(m_pc));
    checkOutput("model_stall",  32'(bus.Stall),
                32'(!m_halted && (m_waiting || (bus.BrReq && bus.CmpEn))));
    checkOutput("model_brdone", 32'(bus.BrDone), 32'(m_brdone));
    checkOutput("model_taken",  32'(bus.Taken),  32'(m_taken));
    checkOutput("model_done",   32'(bus.Done),   32'(m_halted));
`ifdef BRANCH_STATS_EN
    checkOutput("model_count",  32'(bus.TakenCount), 32'(m_count));
`endif
  end

  task automatic applyStimulus(input bit adv, input bit br, input bit cmp, input logic [2:0] cond,
                               input logic [7:0] tgt, input logic [2:0] flags);
    @(posedge Clk);
    #1;
    bus.Advance  = adv;
    bus.BrReq    = br;
    bus.CmpEn    = cmp;
    bus.BrCond   = cond;
    bus.BrTarget = tgt;
    bus.Flags    = flags;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 3'b000);
  endtask

  task automatic pulse_reset();
    @(posedge Clk);
    #1;
    reset = 1'b0;
    bus.Advance = 0; bus.BrReq = 0; bus.CmpEn = 0;
    @(posedge Clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    bus.Advance = 0; bus.BrReq = 0; bus.CmpEn = 0;
    bus.BrCond = 0; bus.BrTarget = 0; bus.Flags = 0;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset_pc",     32'(bus.PC),     32'h0);
    checkOutput("reset_brdone", 32'(bus.BrDone), 32'h0);
    checkOutput("reset_taken",  32'(bus.Taken),  32'h0);
    checkOutput("reset_done",   32'(bus.Done),   32'h0);
    checkOutput("reset_stall",  32'(bus.Stall),  32'h0);
    @(posedge Clk);
    #1 reset = 1'b1;

    // Three sequential steps.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 3'b000);
      else       idle();
      @(negedge Clk);
      checkOutput("adv_pc",     32'(bus.PC),     32'(i));
      checkOutput("adv_brdone", 32'(bus.BrDone), 32'h0);
    end

    // Immediate eq branch, taken.
    applyStimulus(1'b0, 1'b1, 1'b0, COND_EQ, 8'h40, 3'b010);
    idle();
    @(negedge Clk);
    checkOutput("eq_pc",     32'(bus.PC),     32'h40);
    checkOutput("eq_brdone", 32'(bus.BrDone), 32'h1);
    checkOutput("eq_taken",  32'(bus.Taken),  32'h1);
    idle();
    @(negedge Clk);
    checkOutput("eq_brdone_drop", 32'(bus.BrDone), 32'h0);
    checkOutput("eq_taken_hold",  32'(bus.Taken),  32'h1);

    // Collision: gt with CmpEn, flags arrive as 000 next cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, COND_GT, 8'h80, 3'b111);
    @(negedge Clk);
    checkOutput("col_stall0", 32'(bus.Stall), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, COND_ALWAYS, 8'h99, 3'b000);
    @(negedge Clk);
    checkOutput("col_stall1",  32'(bus.Stall),  32'h1);
    checkOutput("col_brdone1", 32'(bus.BrDone), 32'h0);
    checkOutput("col_pc1",     32'(bus.PC),     32'h40);
    idle();
    @(negedge Clk);
    checkOutput("col_pc",     32'(bus.PC),     32'h41);
    checkOutput("col_brdone", 32'(bus.BrDone), 32'h1);
    checkOutput("col_taken",  32'(bus.Taken),  32'h0);
    checkOutput("col_stall2", 32'(bus.Stall),  32'h0);

    // BrReq beats Advance; never-taken steps exactly once.
    applyStimulus(1'b1, 1'b1, 1'b0, COND_NEVER, 8'h90, 3'b111);
    idle();
    @(negedge Clk);
    checkOutput("never_pc",     32'(bus.PC),     32'h42);
    checkOutput("never_brdone", 32'(bus.BrDone), 32'h1);
    checkOutput("never_taken",  32'(bus.Taken),  32'h0);

    // Wrap from all-ones to zero.
    applyStimulus(1'b0, 1'b1, 1'b0, COND_ALWAYS, 8'hFF, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 3'b000);
    @(negedge Clk);
    checkOutput("wrap_ff", 32'(bus.PC), 32'hFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 3'b000);
    @(negedge Clk);
    checkOutput("wrap_00", 32'(bus.PC), 32'h00);

    // Reset while a branch is parked waiting for flags.
    applyStimulus(1'b0, 1'b1, 1'b1, COND_ALWAYS, 8'h55, 3'b000);
    idle();
    @(negedge Clk);
    checkOutput("rstwait_stall", 32'(bus.Stall), 32'h1);
    checkOutput("rstwait_pc",    32'(bus.PC),    32'h01);
    #2 reset = 1'b0;
    #1;
    checkOutput("rstwait_pc0",    32'(bus.PC),    32'h0);
    checkOutput("rstwait_stall0", 32'(bus.Stall), 32'h0);
    @(posedge Clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle();
      @(negedge Clk);
      checkOutput("rstwait_nobrdone", 32'(bus.BrDone), 32'h0);
      checkOutput("rstwait_pchold",   32'(bus.PC),     32'h0);
    end

    // Branch onto the halt address, then requests must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, COND_ALWAYS, HALT, 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b1, COND_ALWAYS, 8'h40, 3'b000);
    @(negedge Clk);
    checkOutput("halt_pc",    32'(bus.PC),    32'h10);
    checkOutput("halt_done",  32'(bus.Done),  32'h1);
    checkOutput("halt_stall", 32'(bus.Stall), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, COND_ALWAYS, 8'h40, 3'b000);
    @(negedge Clk);
    checkOutput("halt_pc_hold", 32'(bus.PC),     32'h10);
    checkOutput("halt_brdone",  32'(bus.BrDone), 32'h0);
    checkOutput("halt_taken",   32'(bus.Taken),  32'h1);
    checkOutput("halt_done2",   32'(bus.Done),   32'h1);

`ifdef BRANCH_STATS_EN
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, COND_ALWAYS, 8'h40, 3'b000);
      @(negedge Clk);
      if (i == 10) checkOutput("stats_count10", 32'(bus.TakenCount), 32'd10);
    end
    idle();
    @(negedge Clk);
    checkOutput("stats_sat", 32'(bus.TakenCount), 32'd255);
`endif

    // Random traffic against the model.
    pulse_reset();
    halt_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge Clk);
      #1;
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
      reset        = ($urandom_range(0, 99) < 2 || halt_cycles > 4) ? 1'b0 : 1'b1;
      bus.Advance  = ($urandom_range(0, 1) == 1);
      bus.BrReq    = ($urandom_range(0, 99) < 35);
      bus.CmpEn    = ($urandom_range(0, 99) < 40);
      bus.BrCond   = 3'($urandom_range(0, 7));
      bus.BrTarget = 8'($urandom_range(0, 255));
      bus.Flags    = 3'($urandom_range(0, 7));
    end
    @(posedge Clk);
    #1 reset = 1'b1;
    idle();
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
